pipe_hazard_ctrl: RTL

- Hazard and sequencing controller for the 16-bit, 5-stage (IF/ID/EX/MEM/WB) CPU pipeline.
- Tracks in-flight register writers in a 3-entry scoreboard and generates forwarding selects for the ID/EX operand muxes.
- Inserts load-use stalls, flushes wrong-path instructions after a taken branch/jump resolved in EX, and freezes the pipeline while data memory is busy.
- Sits beside the control decoder; its outputs drive PC hold, buffer hold/bubble/flush and operand mux selects.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the pipeline hazard controller
package pipe_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_e;
  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       load;
  } sb_entry_t;
  function automatic logic sb_hit(input sb_entry_t e, input logic [3:0] src, input logic use_src,
                                  input logic r0_zero);
    return e.valid && use_src && (e.rd == src) && !(r0_zero && (e.rd == 4'd0));
  endfunction
  function automatic logic [1:0] fwd_sel(input sb_entry_t ex, input sb_entry_t mem, input sb_entry_t wb,
                                         input logic [3:0] src, input logic use_src, input logic r0_zero);
    return sb_hit(ex, src, use_src, r0_zero)  ? (ex.load ? FWD_RF : FWD_EX) :
           sb_hit(mem, src, use_src, r0_zero) ? FWD_MEM :
           sb_hit(wb, src, use_src, r0_zero)  ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: in-flight writer shift register with forward/load-use compare
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       adv_i,
  input  sb_entry_t  ins_i,
  input  logic [3:0] rs_i,
  input  logic [3:0] rt_i,
  input  logic       use_rs_i,
  input  logic       use_rt_i,
  input  logic       kill_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       load_use_o
);
  sb_entry_t ex_q, mem_q, wb_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (adv_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ins_i;
    end
  end
  assign fwd_a_o    = kill_i ? FWD_RF : fwd_sel(ex_q, mem_q, wb_q, rs_i, use_rs_i, R0_ZERO);
  assign fwd_b_o    = kill_i ? FWD_RF : fwd_sel(ex_q, mem_q, wb_q, rt_i, use_rt_i, R0_ZERO);
  assign load_use_o = ex_q.load && (sb_hit(ex_q, rs_i, use_rs_i, R0_ZERO) || sb_hit(ex_q, rt_i, use_rt_i, R0_ZERO));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze sequencing and operand forwarding for the 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter bit R0_ZERO      = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dec_valid_i,
  input  logic [3:0] dec_rs_i,
  input  logic [3:0] dec_rt_i,
  input  logic       dec_use_rs_i,
  input  logic       dec_use_rt_i,
  input  logic [3:0] dec_rd_i,
  input  logic       dec_wen_i,
  input  logic       dec_load_i,
  input  logic       ex_redirect_i,
  input  logic       mem_busy_i,
  output logic       pc_hold_o,
  output logic       ifid_hold_o,
  output logic       idex_bubble_o,
  output logic       flush_ifid_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic [1:0] state_o
);
  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       redir, lu_raw, hold, bubble, flush;
  logic [1:0] fa, fb;
  sb_entry_t  ins;
  assign redir = ~mem_busy_i & (ex_redirect_i | pend_q);
  assign ins   = {dec_valid_i & dec_wen_i & ~bubble, dec_rd_i, dec_load_i};
  hazard_scoreboard #(.R0_ZERO(R0_ZERO)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .adv_i      (~mem_busy_i),
    .ins_i      (ins),
    .rs_i       (dec_rs_i),
    .rt_i       (dec_rt_i),
    .use_rs_i   (dec_use_rs_i),
    .use_rt_i   (dec_use_rt_i),
    .kill_i     ((state_q == FLUSH) | redir),
    .fwd_a_o    (fa),
    .fwd_b_o    (fb),
    .load_use_o (lu_raw)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end
  // freeze beats redirect beats load-use; a redirect seen while frozen is replayed on unfreeze
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hold    = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (mem_busy_i) begin
      hold   = 1'b1;
      pend_d = pend_q | ex_redirect_i;
    end else if (redir) begin
      bubble  = 1'b1;
      flush   = 1'b1;
      pend_d  = 1'b0;
      cnt_d   = 2'(FLUSH_CYCLES - 1);
      state_d = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
    end else begin
      case (state_q)
        RUN: begin
          hold    = dec_valid_i & lu_raw;
          bubble  = dec_valid_i & lu_raw;
          state_d = (dec_valid_i & lu_raw) ? STALL : RUN;
        end
        STALL: state_d = RUN;
        FLUSH: begin
          bubble  = 1'b1;
          cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
          state_d = (cnt_q <= 2'd1) ? RUN : FLUSH;
        end
        default: state_d = RUN;
      endcase
    end
  end
  assign pc_hold_o     = ~rst_i & hold;
  assign ifid_hold_o   = ~rst_i & hold;
  assign idex_bubble_o = ~rst_i & bubble;
  assign flush_ifid_o  = ~rst_i & flush;
  assign fwd_a_o       = rst_i ? FWD_RF : fa;
  assign fwd_b_o       = rst_i ? FWD_RF : fb;
  assign state_o       = state_q;
endmodule
